// File: rtl/uart_tx_arbiter_pkg.sv
// Shared byte width and FSM state type for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

  localparam int BYTE_LEN = 8;
  localparam int GRANT_W  = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first asserted request strictly
// after index 'last', wrapping from NUM_REQ-1 back to 0.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         last,
  output logic               found,
  output logic [2:0]         idx
);

  localparam int IW = $clog2(NUM_REQ);

  logic [3:0] cand;

  // Walk offsets 1..NUM_REQ so 'last' itself is considered only after all others.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last} + 4'(k);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        idx   = cand[2:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter feeding one UART transmitter from NUM_REQ byte streams.
// Optional stall watchdog enabled by defining UART_ARB_TIMEOUT_EN (adds timeout_err port).
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*BYTE_LEN-1:0] req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        uart_data_ready,
  output logic [BYTE_LEN-1:0]         uart_data,
  input  logic                        uart_done,
  output logic [GRANT_W-1:0]          grant_id,
  output logic                        busy
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                        timeout_err
`endif
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  arb_state_e           state, state_n;
  logic [GRANT_W-1:0]   grant_n, last_grant, last_grant_n;
  logic [BYTE_LEN-1:0]  hold_n;
  logic                 held_last, held_last_n;
  logic                 udr_n, busy_n;

  logic [NUM_REQ-1:0]   gmask;
  logic                 gvalid, glast;
  logic [BYTE_LEN-1:0]  gdata;
  logic                 pick_found;
  logic [GRANT_W-1:0]   pick_idx;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] to_cnt, to_cnt_n;
  logic            terr_n;
`endif

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req_valid),
    .last  (last_grant),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Owner's lane, selected through a one-hot mask to keep index widths exact.
  assign gmask  = NUM_REQ'(1) << grant_id;
  assign gvalid = |(req_valid & gmask);
  assign glast  = |(req_last & gmask);

  always_comb begin
    gdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gmask[i]) gdata = req_data[i*BYTE_LEN +: BYTE_LEN];
    end
  end

  always_comb begin
    state_n      = state;
    grant_n      = grant_id;
    last_grant_n = last_grant;
    hold_n       = uart_data;
    held_last_n  = held_last;
    udr_n        = uart_data_ready;
    busy_n       = busy;
    req_ready    = '0;
`ifdef UART_ARB_TIMEOUT_EN
    to_cnt_n     = to_cnt;
    terr_n       = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_n = pick_idx;
          busy_n  = 1'b1;
          state_n = FETCH;
        end
      end
      FETCH: begin
        if (gvalid) begin
          req_ready   = gmask;
          hold_n      = gdata;
          held_last_n = glast;
          udr_n       = 1'b1;
          state_n     = WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
          to_cnt_n    = '0;
        end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          // Owner went silent mid-packet: give the link to someone else.
          last_grant_n = grant_id;
          busy_n       = 1'b0;
          terr_n       = 1'b1;
          to_cnt_n     = '0;
          state_n      = IDLE;
        end else begin
          to_cnt_n = to_cnt + TO_W'(1);
`endif
        end
      end
      WAIT_DONE: begin
        if (uart_done) begin
          udr_n = 1'b0;
          if (held_last) begin
            last_grant_n = grant_id;
            busy_n       = 1'b0;
            state_n      = IDLE;
          end else begin
            state_n = FETCH;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // Reset wins over a capture that would otherwise happen this cycle.
    if (reset) req_ready = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      grant_id        <= '0;
      last_grant      <= GRANT_W'(NUM_REQ - 1);
      uart_data       <= '0;
      held_last       <= 1'b0;
      uart_data_ready <= 1'b0;
      busy            <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      to_cnt          <= '0;
      timeout_err     <= 1'b0;
`endif
    end else begin
      state           <= state_n;
      grant_id        <= grant_n;
      last_grant      <= last_grant_n;
      uart_data       <= hold_n;
      held_last       <= held_last_n;
      uart_data_ready <= udr_n;
      busy            <= busy_n;
`ifdef UART_ARB_TIMEOUT_EN
      to_cnt          <= to_cnt_n;
      timeout_err     <= terr_n;
`endif
    end
  end

endmodule
